fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequences the byte-addressed instruction memory for the LEGv8 core: owns the program counter, drives the memory's 64-bit address, captures each little-endian 32-bit instruction word into a 2-entry fetch buffer, and presents it to decode through a valid/ready handshake. Sits between the instruction memory and the decode stage. Branch/exception redirects flush the buffer and restart fetch at a new target. Out-of-range fetches raise a sticky fault.

## Interface
- RESET_PC, 64'h0, PC loaded on reset
- PC_STEP, 4, byte increment per fetch (16 when the memory is built in pipeline layout)
- IMEM_SIZE, 2048, instruction memory size in bytes; legal fetch iff pc + 4 <= IMEM_SIZE
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- fetch_enable  input  1  level; 0 suppresses new fetches (buffer still drains)
- imem_address  output  64  byte address to instruction memory (= pc)
- imem_data  input  32  instruction word returned combinationally for imem_address
- redirect_valid  input  1  single-cycle redirect strobe
- redirect_target  input  64  new PC on redirect
- out_valid  output  1  buffer head valid
- out_instr  output  32  buffer head instruction
- out_pc  output  64  byte address of out_instr
- out_ready  input  1  decode accepts head this cycle
- fetch_fault  output  1  sticky: misaligned or out-of-range PC
- retired_count  output  32  count of accepted handshakes (out_valid & out_ready)

## Operation
- States: RUN, FAULT. Reset -> RUN, pc=RESET_PC, buffer empty, fetch_fault=0, retired_count=0, out_valid=0, out_instr=0, out_pc=0.
- RUN, push condition: fetch_enable & pc legal & (buffer not full or pop this cycle). On push: {pc, imem_data} written to buffer tail; pc <= pc + PC_STEP.
- Pop: out_valid & out_ready; head removed, retired_count increments (wraps at 2^32).
- Legality: pc[1:0]==0 and pc + 4 <= IMEM_SIZE (compare in 65-bit to avoid wrap). In RUN with fetch_enable=1 and illegal pc: RUN -> FAULT, fetch_fault=1, no push; buffered entries still drain normally.
- FAULT: no pushes; exits only via redirect to a legal target (-> RUN, fetch_fault cleared) or reset. Redirect to illegal target: enter/stay FAULT.
- Redirect priority: redirect_valid overrides push in the same cycle. Buffer cleared, pc <= redirect_target. A simultaneous pop still counts (decode consumed it before the flush).
- fetch_enable=0: pc frozen, no push, no fault check.
- Buffer full (2 entries) and no pop: pc frozen, imem_address held.

## Timing
- imem_address is the registered pc; imem_data is sampled at the same rising edge.
- Reset release -> first instruction at out_valid on the cycle after the first edge (1-cycle fetch latency).
- Steady state with out_ready=1: one instruction per cycle, no bubbles.
- Redirect at edge N: out_valid=0 during cycle N+1 (unless also...: always 0); target instruction valid in cycle N+2.
- out_ready deasserted: buffer fills in at most 2 cycles, then stalls; reasserting out_ready resumes full throughput without bubble (pop and push same edge).
- fetch_fault rises on the edge that evaluates the illegal pc; out_valid remains 1 while older entries drain.
- Asynchronous reset mid-operation: all state cleared immediately, independent of clk.

## Structure
- Shared package legv8_pkg: ADDR_W=64, INSTR_W=32, INSTR_BYTES=4, state enum (RUN, FAULT).
- One sub-module: fetch_fifo (2-entry, 96-bit entries {pc, instr}, push/pop/flush, full/empty, same-cycle push+pop when full).
- Legality compare and PC increment stay in fetch_sequencer.

## Test plan
- Memory preloaded with 0x8b1f03e5, 0xf84000a4, 0x8b040086, 0xf80010a6, 0xf84010a6 at 0,4,8,12,16; out_ready=1 -> out_instr sequence in that order on consecutive cycles, out_pc 0,4,8,12,16, retired_count=5.
- out_ready=0 for 5 cycles after reset -> buffer holds pc 0 and 4, imem_address stuck at 8; release -> 0x8b1f03e5, 0xf84000a4, 0x8b040086 back-to-back.
- Redirect to 16 while head pc=4 -> next out_valid two cycles later with out_instr=0xf84010a6, out_pc=16; pc 8 entries never appear.
- IMEM_SIZE=2048, redirect to 2044 -> one valid fetch at 2044, then fetch_fault=1, no further out_valid; redirect to 0 clears fault, 0x8b1f03e5 returns.
- Redirect to 6 (misaligned) -> fetch_fault=1 next cycle, out_valid=0.
- Assert reset asynchronously mid-stream -> out_valid, fetch_fault, retired_count all 0 before next edge; imem_address=RESET_PC.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch-path widths, fetch FSM states and the fetch buffer entry layout.
package legv8_pkg;

    localparam int ADDR_W      = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} fetch buffer; a full buffer accepts a push on the same edge as a pop.
module fetch_fifo
    import legv8_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_entry,
    output logic         full,
    output logic         empty
);

    fetch_entry_t slots [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // A flush discards everything, including anything offered on the same edge.
    assign do_push = push & (~full | pop) & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    assign head_entry = slots[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                slots[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_entry;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the LEGv8 program counter, fetches instruction words into a 2-entry buffer
// and hands them to decode; redirects flush and restart, bad PCs raise a sticky fault.
module fetch_sequencer
    import legv8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 64'h0,
    parameter int unsigned       PC_STEP   = 4,
    parameter int unsigned       IMEM_SIZE = 2048
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_enable,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    output logic               fetch_fault,
    output logic [31:0]        retired_count
);

    localparam int SUM_W = ADDR_W + 1;

    fetch_state_t state;
    logic [ADDR_W-1:0] pc;
    logic         pc_legal;
    logic         target_legal;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // One extra bit keeps pc + 4 from wrapping near the top of the address space.
    function automatic logic is_legal(input logic [ADDR_W-1:0] addr);
        logic [SUM_W-1:0] end_addr;
        end_addr = {1'b0, addr} + SUM_W'(INSTR_BYTES);
        return (addr[1:0] == 2'b00) && (end_addr <= SUM_W'(IMEM_SIZE));
    endfunction

    assign pc_legal     = is_legal(pc);
    assign target_legal = is_legal(redirect_target);

    assign out_valid    = ~fifo_empty;
    assign out_instr    = head_entry.instr;
    assign out_pc       = head_entry.pc;
    assign imem_address = pc;
    assign fetch_fault  = (state == FAULT);

    assign pop  = out_valid & out_ready;
    assign push = (state == RUN) & fetch_enable & pc_legal & ~redirect_valid
                & (~fifo_full | pop);

    assign push_entry = '{pc: pc, instr: imem_data};

    // A redirect wins over everything else and decides on its own whether fetch may resume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else if (redirect_valid) begin
            pc    <= redirect_target;
            state <= target_legal ? RUN : FAULT;
        end else if (state == RUN && fetch_enable) begin
            if (!pc_legal) begin
                state <= FAULT;
            end else if (push) begin
                pc <= pc + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= 32'd0;
        end else if (pop) begin
            retired_count <= retired_count + 32'd1;
        end
    end

    fetch_fifo u_fetch_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected {pc, instr} pairs are queued as stimulus
// is applied and retired against every accepted decode handshake.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        fetch_enable;
    logic [63:0] imem_address;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;
    logic        fetch_fault;
    logic [31:0] retired_count;

    logic [31:0] mem [0:511];
    exp_t        exp_q [$];
    int          check_count;
    int          pass_count;
    int          seen_handshakes;
    int          drain_cycles;

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_enable    (fetch_enable),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_ready       (out_ready),
        .fetch_fault     (fetch_fault),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = (imem_address < 64'd2048) ? mem[imem_address[10:2]] : 32'h0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic enable,
                                 input logic rv, input logic [63:0] target);
        out_ready       = ready;
        fetch_enable    = enable;
        redirect_valid  = rv;
        redirect_target = target;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [63:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem[pc[10:2]];
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 50) begin
            step();
            cycles++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        seen_handshakes = 0;
        step();
        reset = 1'b0;
    endtask

    // Every accepted handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            seen_handshakes++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_handshake", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_pc", out_pc, e.pc);
                checkOutput("sb_instr", {32'h0, out_instr}, {32'h0, e.instr});
            end
        end
    end

    initial begin
        check_count = 0;
        pass_count = 0;
        seen_handshakes = 0;
        for (int i = 0; i < 512; i++) begin
            mem[i] = 32'hC0DE_0000 + 32'(i);
        end
        mem[0] = 32'h8b1f03e5;
        mem[1] = 32'hf84000a4;
        mem[2] = 32'h8b040086;
        mem[3] = 32'hf80010a6;
        mem[4] = 32'hf84010a6;

        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        repeat (2) step();
        checkOutput("rst_valid", {63'h0, out_valid}, 64'd0);
        checkOutput("rst_fault", {63'h0, fetch_fault}, 64'd0);
        checkOutput("rst_retired", {32'h0, retired_count}, 64'd0);
        checkOutput("rst_addr", imem_address, 64'd0);
        checkOutput("rst_instr", {32'h0, out_instr}, 64'd0);
        checkOutput("rst_pc", out_pc, 64'd0);

        // Straight-line stream at full throughput.
        for (int i = 0; i < 5; i++) expect_fetch(64'(4 * i));
        reset = 1'b0;
        wait_drain(drain_cycles);
        checkOutput("stream_cycles", 64'(drain_cycles), 64'd6);
        checkOutput("stream_retired", {32'h0, retired_count}, 64'd5);
        out_ready = 1'b0;

        // Back-pressure: buffer fills with pc 0 and 4, then drains without bubbles.
        do_reset();
        repeat (5) step();
        checkOutput("bp_addr", imem_address, 64'd8);
        checkOutput("bp_valid", {63'h0, out_valid}, 64'd1);
        checkOutput("bp_head_pc", out_pc, 64'd0);
        checkOutput("bp_retired", {32'h0, retired_count}, 64'd0);
        for (int i = 0; i < 3; i++) expect_fetch(64'(4 * i));
        out_ready = 1'b1;
        wait_drain(drain_cycles);
        checkOutput("bp_cycles", 64'(drain_cycles), 64'd3);
        out_ready = 1'b0;

        // Redirect to 16 while head is pc 4; pc 8 must never surface.
        out_ready = 1'b1;
        do_reset();
        expect_fetch(64'd0);
        expect_fetch(64'd4);
        expect_fetch(64'd16);
        expect_fetch(64'd20);
        step();
        step();
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd16);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        checkOutput("rd_bubble", {63'h0, out_valid}, 64'd0);
        checkOutput("rd_retired", {32'h0, retired_count}, 64'(seen_handshakes));
        checkOutput("rd_retired2", {32'h0, retired_count}, 64'd2);
        checkOutput("rd_addr", imem_address, 64'd16);
        step();
        checkOutput("rd_valid", {63'h0, out_valid}, 64'd1);
        checkOutput("rd_pc", out_pc, 64'd16);
        checkOutput("rd_instr", {32'h0, out_instr}, 64'h0000_0000_f840_10a6);
        wait_drain(drain_cycles);
        out_ready = 1'b0;

        // Last legal word at 2044, then the fetch at 2048 faults.
        applyStimulus(1'b0, 1'b1, 1'b1, 64'd2044);
        expect_fetch(64'd2044);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        checkOutput("top_fault0", {63'h0, fetch_fault}, 64'd0);
        checkOutput("top_flushed", {63'h0, out_valid}, 64'd0);
        checkOutput("top_addr", imem_address, 64'd2044);
        step();
        checkOutput("top_valid", {63'h0, out_valid}, 64'd1);
        checkOutput("top_pc", out_pc, 64'd2044);
        checkOutput("top_fault1", {63'h0, fetch_fault}, 64'd0);
        step();
        checkOutput("top_fault2", {63'h0, fetch_fault}, 64'd1);
        checkOutput("top_valid2", {63'h0, out_valid}, 64'd0);
        checkOutput("top_retired", {32'h0, retired_count}, 64'(seen_handshakes));
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("fault_idle", {63'h0, out_valid}, 64'd0);
        end
        checkOutput("fault_addr", imem_address, 64'd2048);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'd0);
        expect_fetch(64'd0);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        checkOutput("recover_fault", {63'h0, fetch_fault}, 64'd0);
        step();
        checkOutput("recover_valid", {63'h0, out_valid}, 64'd1);
        checkOutput("recover_instr", {32'h0, out_instr}, 64'h0000_0000_8b1f_03e5);
        step();
        out_ready = 1'b0;
        checkOutput("recover_drained", 64'(exp_q.size()), 64'd0);

        // Misaligned redirect faults immediately.
        applyStimulus(1'b0, 1'b1, 1'b1, 64'd6);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 64'd0);
        checkOutput("mis_fault", {63'h0, fetch_fault}, 64'd1);
        checkOutput("mis_valid", {63'h0, out_valid}, 64'd0);
        step();
        checkOutput("mis_addr", imem_address, 64'd6);

        // Asynchronous reset mid-cycle while faulted.
        #3;
        reset = 1'b1;
        seen_handshakes = 0;
        #1;
        checkOutput("arst_fault", {63'h0, fetch_fault}, 64'd0);
        checkOutput("arst_retired", {32'h0, retired_count}, 64'd0);
        checkOutput("arst_addr", imem_address, 64'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        reset = 1'b0;
        repeat (2) step();
        checkOutput("noen_addr", imem_address, 64'd0);
        checkOutput("noen_valid", {63'h0, out_valid}, 64'd0);
        fetch_enable = 1'b1;
        repeat (3) step();
        checkOutput("full_valid", {63'h0, out_valid}, 64'd1);
        checkOutput("full_addr", imem_address, 64'd8);

        // Asynchronous reset with a full buffer.
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst2_valid", {63'h0, out_valid}, 64'd0);
        checkOutput("arst2_addr", imem_address, 64'd0);
        checkOutput("arst2_pc", out_pc, 64'd0);
        step();
        checkOutput("final_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
